// File: rtl/e8_resp_compactor.sv
// Response compactor for the e8 controller: Galois MISR signature plus sample counter over a
// start/stop window, result handed off via sig_valid/sig_ack. Optional macro: ZERO_CNT_EN.
module e8_resp_compactor #(
  parameter int unsigned      WIDTH       = 20,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [WIDTH-1:0] POLY        = 20'h00009,
  parameter logic [WIDTH-1:0] SEED        = 20'h00000,
  parameter int unsigned      MAX_SAMPLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] y_in,
  input  logic             start,
  input  logic             stop,
  input  logic             smp_en,
  input  logic             sig_ack,
  output logic             busy,
  output logic             sig_valid,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] smp_cnt,
  output logic             cnt_ovf
`ifdef ZERO_CNT_EN
  ,
  output logic [CNT_W-1:0] zero_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   misr_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               cnt_sat;
  logic               max_hit;
`ifdef ZERO_CNT_EN
  logic [CNT_W-1:0]   zcnt_q, zcnt_d;
`endif

  assign misr_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ y_in;
  assign cnt_sat   = &cnt_q;
  assign cnt_inc   = cnt_sat ? cnt_q : cnt_q + 1'b1;
  assign max_hit   = (MAX_SAMPLES != 0) && (cnt_inc == CNT_W'(MAX_SAMPLES));

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef ZERO_CNT_EN
    zcnt_d  = zcnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          sig_d   = SEED;
          cnt_d   = '0;
          ovf_d   = 1'b0;
`ifdef ZERO_CNT_EN
          zcnt_d  = '0;
`endif
        end
      end
      StRun: begin
        // start outranks stop and any pending sample
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          ovf_d   = 1'b0;
`ifdef ZERO_CNT_EN
          zcnt_d  = '0;
`endif
        end else if (smp_en) begin
          sig_d = misr_next;
          cnt_d = cnt_inc;
          if (cnt_sat) ovf_d = 1'b1;
`ifdef ZERO_CNT_EN
          if (y_in == '0 && !(&zcnt_q)) zcnt_d = zcnt_q + 1'b1;
`endif
          if (stop || max_hit) state_d = StDone;
        end else if (stop) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (sig_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d  = (state_d == StRun);
    valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sig_q   <= SEED;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef ZERO_CNT_EN
      zcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
`ifdef ZERO_CNT_EN
      zcnt_q  <= zcnt_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign sig_valid = valid_q;
  assign signature = sig_q;
  assign smp_cnt   = cnt_q;
  assign cnt_ovf   = ovf_q;
`ifdef ZERO_CNT_EN
  assign zero_cnt  = zcnt_q;
`endif

endmodule

// File: tb/tb_e8_resp_compactor.sv
// Directed bench for e8_resp_compactor; four parameterisations share one stimulus bus.
module tb_e8_resp_compactor;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] y_in;
  logic        start, stop, smp_en, sig_ack;

  logic        busy_a, valid_a, ovf_a;
  logic [19:0] sig_a;
  logic [15:0] cnt_a, zc_a;
  logic        busy_b, valid_b, ovf_b;
  logic [19:0] sig_b;
  logic [15:0] cnt_b, zc_b;
  logic        busy_m, valid_m, ovf_m;
  logic [19:0] sig_m;
  logic [15:0] cnt_m, zc_m;
  logic        busy_c, valid_c, ovf_c;
  logic [19:0] sig_c;
  logic [2:0]  cnt_c, zc_c;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  e8_resp_compactor u_dut (
    .clk(clk), .rst(rst), .y_in(y_in), .start(start), .stop(stop), .smp_en(smp_en),
    .sig_ack(sig_ack), .busy(busy_a), .sig_valid(valid_a), .signature(sig_a),
    .smp_cnt(cnt_a), .cnt_ovf(ovf_a)
`ifdef ZERO_CNT_EN
    , .zero_cnt(zc_a)
`endif
  );

  e8_resp_compactor #(.SEED(20'h80000)) u_seed (
    .clk(clk), .rst(rst), .y_in(y_in), .start(start), .stop(stop), .smp_en(smp_en),
    .sig_ack(sig_ack), .busy(busy_b), .sig_valid(valid_b), .signature(sig_b),
    .smp_cnt(cnt_b), .cnt_ovf(ovf_b)
`ifdef ZERO_CNT_EN
    , .zero_cnt(zc_b)
`endif
  );

  e8_resp_compactor #(.MAX_SAMPLES(4)) u_max (
    .clk(clk), .rst(rst), .y_in(y_in), .start(start), .stop(stop), .smp_en(smp_en),
    .sig_ack(sig_ack), .busy(busy_m), .sig_valid(valid_m), .signature(sig_m),
    .smp_cnt(cnt_m), .cnt_ovf(ovf_m)
`ifdef ZERO_CNT_EN
    , .zero_cnt(zc_m)
`endif
  );

  e8_resp_compactor #(.CNT_W(3)) u_c3 (
    .clk(clk), .rst(rst), .y_in(y_in), .start(start), .stop(stop), .smp_en(smp_en),
    .sig_ack(sig_ack), .busy(busy_c), .sig_valid(valid_c), .signature(sig_c),
    .smp_cnt(cnt_c), .cnt_ovf(ovf_c)
`ifdef ZERO_CNT_EN
    , .zero_cnt(zc_c)
`endif
  );

`ifndef ZERO_CNT_EN
  assign zc_a = '0;
  assign zc_b = '0;
  assign zc_m = '0;
  assign zc_c = '0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; stop = 0; smp_en = 0; sig_ack = 0; y_in = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; idle_in();
    #2;
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    n_cmp++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_a); end
    n_cmp++; if (sig_a !== 20'h0) begin n_fail++; $display("FAIL rst_sig: got %h want 00000", sig_a); end
    n_cmp++; if (sig_b !== 20'h80000) begin n_fail++; $display("FAIL rst_seed: got %h want 80000", sig_b); end
    n_cmp++; if (cnt_a !== 16'd0 || ovf_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_cnt: got %0d/%b want 0/0", cnt_a, ovf_a); end
    n_cmp++; if (zc_a !== 16'd0) begin n_fail++; $display("FAIL rst_zcnt: got %0d want 0", zc_a); end
    tick(); rst = 0; tick();
    // stop and ack are ignored in IDLE
    stop = 1; sig_ack = 1; smp_en = 1; y_in = 20'h1;
    tick();
    n_cmp++; if (valid_a !== 1'b0 || busy_a !== 1'b0 || sig_a !== 20'h0) begin
      n_fail++; $display("FAIL idle_stop: got v%b b%b %h want v0 b0 00000", valid_a, busy_a, sig_a); end
  endtask

  task automatic test_basic();
    do_reset();
    start = 1; smp_en = 1; y_in = 20'h1;
    tick();
    n_cmp++; if (busy_a !== 1'b1 || sig_a !== 20'h0) begin
      n_fail++; $display("FAIL t1_start: got b%b %h want b1 00000", busy_a, sig_a); end
    start = 0;
    tick();
    stop = 1;
    tick();
    n_cmp++; if (sig_a !== 20'h00003) begin n_fail++; $display("FAIL t1_sig: got %h want 00003", sig_a); end
    n_cmp++; if (cnt_a !== 16'd2) begin n_fail++; $display("FAIL t1_cnt: got %0d want 2", cnt_a); end
    n_cmp++; if (valid_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL t1_valid: got v%b b%b want v1 b0", valid_a, busy_a); end
    idle_in(); smp_en = 1; y_in = 20'hABCDE;
    tick();
    n_cmp++; if (sig_a !== 20'h00003 || cnt_a !== 16'd2 || valid_a !== 1'b1) begin
      n_fail++; $display("FAIL t1_frozen: got %h/%0d/%b want 00003/2/1", sig_a, cnt_a, valid_a); end
  endtask

  task automatic test_poly();
    do_reset();
    start = 1;
    tick();
    start = 0; smp_en = 1; y_in = 20'h0; stop = 1;
    tick();
    n_cmp++; if (sig_b !== 20'h00009) begin n_fail++; $display("FAIL t2_sig: got %h want 00009", sig_b); end
    n_cmp++; if (cnt_b !== 16'd1 || valid_b !== 1'b1) begin
      n_fail++; $display("FAIL t2_cnt: got %0d/%b want 1/1", cnt_b, valid_b); end
  endtask

  task automatic test_max_samples();
    do_reset();
    start = 1; smp_en = 1; y_in = 20'h1;
    tick();
    start = 0;
    repeat (3) tick();
    n_cmp++; if (sig_m !== 20'h00007 || valid_m !== 1'b0 || busy_m !== 1'b1) begin
      n_fail++; $display("FAIL t3_pre: got %h v%b b%b want 00007 v0 b1", sig_m, valid_m, busy_m); end
    tick();
    n_cmp++; if (valid_m !== 1'b1 || cnt_m !== 16'd4 || sig_m !== 20'h0000F) begin
      n_fail++; $display("FAIL t3_done: got v%b %0d %h want v1 4 0000f", valid_m, cnt_m, sig_m); end
    tick();
    tick();
    n_cmp++; if (valid_m !== 1'b1 || cnt_m !== 16'd4 || sig_m !== 20'h0000F) begin
      n_fail++; $display("FAIL t3_hold: got v%b %0d %h want v1 4 0000f", valid_m, cnt_m, sig_m); end
    idle_in(); sig_ack = 1;
    tick();
    n_cmp++; if (valid_m !== 1'b0 || busy_m !== 1'b0 || sig_m !== 20'h0000F) begin
      n_fail++; $display("FAIL t3_ack: got v%b b%b %h want v0 b0 0000f", valid_m, busy_m, sig_m); end
  endtask

  task automatic test_saturate();
    do_reset();
    start = 1;
    tick();
    start = 0; smp_en = 1; y_in = 20'h0;
    repeat (7) tick();
    n_cmp++; if (cnt_c !== 3'd7 || ovf_c !== 1'b0) begin
      n_fail++; $display("FAIL t4_seven: got %0d/%b want 7/0", cnt_c, ovf_c); end
    tick();
    stop = 1;
    tick();
    n_cmp++; if (cnt_c !== 3'd7 || ovf_c !== 1'b1 || valid_c !== 1'b1) begin
      n_fail++; $display("FAIL t4_sat: got %0d/%b/v%b want 7/1/v1", cnt_c, ovf_c, valid_c); end
    idle_in(); start = 1;
    tick();
    n_cmp++; if (valid_c !== 1'b1 || busy_c !== 1'b0 || cnt_c !== 3'd7) begin
      n_fail++; $display("FAIL t4_done_start: got v%b b%b %0d want v1 b0 7", valid_c, busy_c, cnt_c); end
    sig_ack = 1;
    tick();
    n_cmp++; if (valid_c !== 1'b0 || busy_c !== 1'b0) begin
      n_fail++; $display("FAIL t4_ack_start: got v%b b%b want v0 b0", valid_c, busy_c); end
    sig_ack = 0;
    tick();
    n_cmp++; if (busy_c !== 1'b1 || cnt_c !== 3'd0 || ovf_c !== 1'b0) begin
      n_fail++; $display("FAIL t4_restart: got b%b %0d/%b want b1 0/0", busy_c, cnt_c, ovf_c); end
  endtask

  task automatic test_stall_restart();
    do_reset();
    start = 1; smp_en = 1; y_in = 20'h1;
    tick();
    start = 0;
    tick();
    tick();
    smp_en = 0; y_in = 20'h12345;
    repeat (5) tick();
    n_cmp++; if (sig_a !== 20'h00003 || cnt_a !== 16'd2 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL t5_stall: got %h/%0d/b%b want 00003/2/b1", sig_a, cnt_a, busy_a); end
    start = 1; stop = 1; smp_en = 1;
    tick();
    n_cmp++; if (busy_a !== 1'b1 || valid_a !== 1'b0 || sig_a !== 20'h0 || cnt_a !== 16'd0) begin
      n_fail++; $display("FAIL t5_restart: got b%b v%b %h %0d want b1 v0 00000 0",
                         busy_a, valid_a, sig_a, cnt_a); end
    start = 0; stop = 0; y_in = 20'h1;
    tick();
    n_cmp++; if (sig_a !== 20'h00001 || cnt_a !== 16'd1) begin
      n_fail++; $display("FAIL t5_resume: got %h/%0d want 00001/1", sig_a, cnt_a); end
    #2;
    rst = 1;
    #1;
    n_cmp++; if (busy_a !== 1'b0 || valid_a !== 1'b0 || sig_a !== 20'h0 || cnt_a !== 16'd0) begin
      n_fail++; $display("FAIL t5_async_rst: got b%b v%b %h %0d want b0 v0 00000 0",
                         busy_a, valid_a, sig_a, cnt_a); end
    n_cmp++; if (sig_b !== 20'h80000) begin n_fail++; $display("FAIL t5_rst_seed: got %h want 80000", sig_b); end
    idle_in();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_stop_no_sample();
    do_reset();
    start = 1;
    tick();
    start = 0; smp_en = 1; y_in = 20'h1;
    tick();
    smp_en = 0; stop = 1; y_in = 20'hFFFFF;
    tick();
    n_cmp++; if (valid_a !== 1'b1 || sig_a !== 20'h00001 || cnt_a !== 16'd1) begin
      n_fail++; $display("FAIL stop_nosmp: got v%b %h %0d want v1 00001 1", valid_a, sig_a, cnt_a); end
  endtask

  task automatic test_zero_cnt();
    do_reset();
    start = 1;
    tick();
    start = 0; smp_en = 1; y_in = 20'h0;
    tick();
    tick();
    y_in = 20'h5;
    tick();
    y_in = 20'h0; stop = 1;
    tick();
    n_cmp++; if (sig_a !== 20'h0000A || cnt_a !== 16'd4) begin
      n_fail++; $display("FAIL t6_sig: got %h/%0d want 0000a/4", sig_a, cnt_a); end
`ifdef ZERO_CNT_EN
    n_cmp++; if (zc_a !== 16'd3) begin n_fail++; $display("FAIL t6_zcnt: got %0d want 3", zc_a); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_poly();
    test_max_samples();
    test_saturate();
    test_stall_restart();
    test_stop_no_sample();
    test_zero_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
